// File: rtl/fifo_pop_serializer_pkg.sv
// Shared types and line levels for the FIFO pop serializer.
// Imported by the serializer top and its bit timer.
package fifo_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/fifo_pop_serializer_bit_timer.sv
// Baud counter for the serializer.
// tick marks the last cycle of each bit period.
module bit_timer
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_cnt_d;

  // Count 0..CLKS_PER_BIT-1 and wrap; clear parks it at 0.
  always_comb begin
    baud_cnt_d = baud_cnt + CW'(1);
    if (clear || baud_cnt == LAST) begin
      baud_cnt_d = '0;
    end
  end

  assign tick      = (baud_cnt == LAST);
  assign tick_next = (baud_cnt_d == LAST);

  // Baud counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt_d;
    end
  end

endmodule

// File: rtl/fifo_pop_serializer.sv
// FIFO read-side engine: pops one word per frame and sends it
// as start bit, WIDTH data bits LSB first, stop bit.
module fifo_pop_serializer
  import fifo_tx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             pop,
  input  logic             tx_en,
  output logic             serial_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_e state_q;
  tx_state_e state_d;

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [BW-1:0]    bit_q;
  logic [BW-1:0]    bit_d;

  logic pop_d;
  logic serial_d;
  logic busy_d;
  logic done_d;

  logic tick;
  logic tick_next;
  logic timer_clear;

  // Timer restarts so START always gets a full bit period.
  assign timer_clear = (state_q == IDLE) || (state_q == WAIT);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .tick     (tick),
    .tick_next(tick_next)
  );

  // State, shift register and bit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // Next state plus shift/bit-count datapath.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (pop) state_d = WAIT;
      end
      WAIT: begin
        shift_d = fifo_data;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the coming state so the flops
  // line up with it; pop issues only from an idle cycle.
  always_comb begin
    pop_d    = (state_d == IDLE) && tx_en && !fifo_empty;
    busy_d   = (state_d != IDLE) || pop_d;
    done_d   = (state_d == STOP) && tick_next;
    serial_d = IDLE_LEVEL;
    unique case (state_d)
      START:   serial_d = START_LEVEL;
      DATA:    serial_d = shift_d[0];
      STOP:    serial_d = STOP_LEVEL;
      default: serial_d = IDLE_LEVEL;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop        <= 1'b0;
      serial_out <= IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pop        <= pop_d;
      serial_out <= serial_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// Directed bench for fifo_pop_serializer.
// Small FIFO model feeds the main DUT; a second DUT runs at one clk per bit.
module tb_fifo_pop_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [3:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic fifo_empty;
  logic [3:0] fifo_data = '0;
  logic tx_en = 1'b0;
  logic pop, serial_out, busy, frame_done;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_pop_serializer #(
    .WIDTH(4), .CLKS_PER_BIT(4)
  ) dut (
    .clk(clk), .reset(rst_n),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .pop(pop), .tx_en(tx_en),
    .serial_out(serial_out), .busy(busy),
    .frame_done(frame_done)
  );

  logic fifo_empty1 = 1'b1;
  logic [3:0] fifo_data1 = '0;
  logic tx_en1 = 1'b0;
  logic pop1, serial1, busy1, done1;

  fifo_pop_serializer #(
    .WIDTH(4), .CLKS_PER_BIT(1)
  ) dut1 (
    .clk(clk), .reset(rst_n),
    .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .pop(pop1), .tx_en(tx_en1),
    .serial_out(serial1), .busy(busy1),
    .frame_done(done1)
  );

  always @(posedge clk) begin
    if (pop && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[4:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int pop_cnt = 0;
  int bad_pop = 0;
  always @(negedge clk) begin
    if (pop === 1'b1) pop_cnt <= pop_cnt + 1;
    if (pop === 1'b1 && fifo_empty) bad_pop <= bad_pop + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] w);
    mem[wr_ptr[4:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_pop(output bit ok, output int n);
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n = n + 1;
      if (pop === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic capture(output logic [24:0] ser,
                         output logic [25:0] bsy,
                         output logic [25:0] dn);
    bsy[0] = busy;
    dn[0] = frame_done;
    for (int i = 1; i < 26; i++) begin
      tick();
      ser[i-1] = serial_out;
      bsy[i] = busy;
      dn[i] = frame_done;
    end
  endtask

  function automatic logic [24:0] expand(input logic [5:0] lv);
    logic [24:0] e;
    e[0] = 1'b1;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 4; j++)
        e[1 + 4*k + j] = lv[k];
    return e;
  endfunction

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    tx_en = 1'b1;
    repeat (3) tick();
    checks++;
    if ({serial_out, pop, busy, frame_done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_hold got=%b want=1000",
               {serial_out, pop, busy, frame_done});
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (serial_out !== 1'b1 || pop !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle bad_cycles=%0d want=0", bad);
    end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    logic [24:0] ser;
    logic [25:0] bsy, dn;
    push(4'b0011);
    wait_pop(ok, n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_pop got=timeout want=pop");
      return;
    end
    capture(ser, bsy, dn);
    checks++;
    if (ser !== expand(6'b100110)) begin
      failures++;
      $display("FAIL single_serial got=%b want=%b",
               ser, expand(6'b100110));
    end
    checks++;
    if (dn !== 26'h2000000) begin
      failures++;
      $display("FAIL single_done got=%h want=2000000", dn);
    end
    checks++;
    if (bsy !== 26'h3ffffff) begin
      failures++;
      $display("FAIL single_busy got=%h want=3ffffff", bsy);
    end
    tick();
    checks++;
    if ({busy, pop, serial_out} !== 3'b001) begin
      failures++;
      $display("FAIL single_after got=%b want=001",
               {busy, pop, serial_out});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] lv [4];
    bit ok;
    int n, p0;
    logic [24:0] ser;
    logic [25:0] bsy, dn;
    lv[0] = 6'b100110;
    lv[1] = 6'b100100;
    lv[2] = 6'b101000;
    lv[3] = 6'b101010;
    tx_en = 1'b0;
    tick();
    p0 = pop_cnt;
    push(4'b0011);
    push(4'b0010);
    push(4'b0100);
    push(4'b0101);
    tx_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_pop(ok, n);
      checks++;
      if (!ok || (f > 0 && n != 1)) begin
        failures++;
        $display("FAIL b2b_gap frame=%0d ok=%0d ticks=%0d want=1",
                 f, ok, n);
        return;
      end
      capture(ser, bsy, dn);
      checks++;
      if (ser !== expand(lv[f])) begin
        failures++;
        $display("FAIL b2b_serial frame=%0d got=%b want=%b",
                 f, ser, expand(lv[f]));
      end
    end
    repeat (40) tick();
    checks++;
    if (pop_cnt - p0 != 4 || bad_pop != 0) begin
      failures++;
      $display("FAIL b2b_pops got=%0d bad=%0d want=4 bad=0",
               pop_cnt - p0, bad_pop);
    end
  endtask

  task automatic test_enable_gating();
    bit ok;
    int n, p0, dcnt, pc;
    tx_en = 1'b0;
    push(4'b0001);
    push(4'b0110);
    push(4'b1111);
    tx_en = 1'b1;
    wait_pop(ok, n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL gate_pop got=timeout want=pop");
      return;
    end
    p0 = pop_cnt;
    repeat (8) tick();
    tx_en = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (frame_done === 1'b1) dcnt++;
    end
    checks++;
    if (pop_cnt != p0 || dcnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gate_hold pops=%0d done=%0d busy=%b want=0 1 0",
               pop_cnt - p0, dcnt, busy);
    end
    tx_en = 1'b1;
    tick();
    checks++;
    if (pop !== 1'b1) begin
      failures++;
      $display("FAIL gate_resume pop=%b want=1", pop);
    end
    pc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (fifo_empty && busy === 1'b0) break;
      pc++;
    end
    checks++;
    if (pc >= 300 || pop_cnt != p0 + 2) begin
      failures++;
      $display("FAIL gate_drain cycles=%0d pops=%0d want=<300 2",
               pc, pop_cnt - p0);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n;
    logic [24:0] ser;
    logic [25:0] bsy, dn;
    push(4'b1001);
    push(4'b0110);
    wait_pop(ok, n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_pop got=timeout want=pop");
      return;
    end
    repeat (10) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({serial_out, busy, pop} !== 3'b100) begin
      failures++;
      $display("FAIL midrst_async got=%b want=100",
               {serial_out, busy, pop});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    wait_pop(ok, n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_repop got=timeout want=pop");
      return;
    end
    capture(ser, bsy, dn);
    checks++;
    if (ser !== expand(6'b101100) || dn[25] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_frame got=%b done=%b want=%b 1",
               ser, dn[25], expand(6'b101100));
    end
  endtask

  task automatic test_clk1();
    bit ok;
    logic [6:0] s;
    logic d7, b8;
    ok = 1'b0;
    tx_en1 = 1'b1;
    fifo_empty1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pop1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clk1_pop got=timeout want=pop");
      return;
    end
    fifo_empty1 = 1'b1;
    fifo_data1 = 4'b1010;
    for (int i = 0; i < 7; i++) begin
      tick();
      s[i] = serial1;
    end
    d7 = done1;
    tick();
    b8 = busy1;
    checks++;
    if (s !== 7'b1101001) begin
      failures++;
      $display("FAIL clk1_serial got=%b want=1101001", s);
    end
    checks++;
    if (d7 !== 1'b1 || b8 !== 1'b0) begin
      failures++;
      $display("FAIL clk1_end done=%b busy=%b want=1 0", d7, b8);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_frame();
    test_clk1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
